dm_arbiter: RTL and testbench

Single-port arbiter and byte-lane controller in front of the word-addressed data memory. It shares the memory's one access per cycle between two requesters: the CPU MEM stage (port C, priority) and an auxiliary DMA/debug master (port A, valid/ready). Because memory read is combinational, sub-word stores become a single-cycle read-merge-write. A bounded starvation counter guarantees port A forward progress.

---
 rtl/dm_arb_pkg.sv | 29 ++
 rtl/dm_byte_merge.sv | 17 +
 rtl/dm_arbiter.sv | 119 +++++++++++
 tb/tb_dm_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Lane mask expansion, port selection encoding and the request bundle.
package dm_arb_pkg;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      PORT_NONE,
      PORT_C,
      PORT_A
   } port_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++) begin
         mask[i*8 +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge of a new word into the current memory word; purely combinational,
// zero latency, no flow control of its own.
module dm_byte_merge
   import dm_arb_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   logic [31:0] mask;

   assign mask   = be_to_mask(be);
   assign merged = (old_word & ~mask) | (new_word & mask);

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU port has priority, aux port gets a forced grant after
// STARVE_MAX denied cycles; zero-latency memory access, aux read data one cycle after accept.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [3:0]  c_be,
   input  logic [31:0] c_wdata,
   output logic [31:0] c_rdata,
   output logic        c_stall,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [3:0]  a_be,
   input  logic [31:0] a_wdata,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,
   output logic        a_err,
   output logic [29:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_we,
   input  logic [31:0] m_rdata
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   function automatic logic in_range(input logic [31:0] addr);
      return (addr >> (ADDR_W + 2)) == 32'd0;
   endfunction

   logic [STARVE_W-1:0] starve;
   logic                grant_a;
   logic                grant_c;
   port_e               sel;
   req_t                c_side;
   req_t                a_side;
   req_t                act;
   logic                act_in_range;
   logic                c_in_range;
   logic                a_in_range;
   logic                a_rd_accept;

   assign grant_a = a_valid && (!c_req || starve == STARVE_LIM);
   assign grant_c = c_req && !grant_a;

   assign c_stall = c_req && grant_a;
   assign a_ready = grant_a;

   assign c_side = '{we: c_we, addr: c_addr, be: c_be, wdata: c_wdata};
   assign a_side = '{we: a_we, addr: a_addr, be: a_be, wdata: a_wdata};

   always_comb begin
      sel = PORT_NONE;
      if (grant_a) begin
         sel = PORT_A;
      end else if (grant_c) begin
         sel = PORT_C;
      end
   end

   // With no grant the CPU address still drives the memory so its read path stays quiet.
   always_comb begin
      act = c_side;
      case (sel)
         PORT_A:  act = a_side;
         PORT_C:  act = c_side;
         default: act = '{we: 1'b0, addr: c_addr, be: 4'h0, wdata: 32'h0};
      endcase
   end

   assign act_in_range = in_range(act.addr);
   assign c_in_range   = in_range(c_addr);
   assign a_in_range   = in_range(a_addr);

   assign m_addr = act.addr[31:2];
   assign m_we   = (sel != PORT_NONE) && act.we && (act.be != 4'h0) && act_in_range;

   dm_byte_merge u_merge (
      .old_word (m_rdata),
      .new_word (act.wdata),
      .be       (act.be),
      .merged   (m_wdata)
   );

   assign c_rdata     = (grant_c && c_in_range) ? m_rdata : 32'h0;
   assign a_rd_accept = grant_a && !a_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve   <= '0;
         a_rvalid <= 1'b0;
         a_rdata  <= 32'h0;
         a_err    <= 1'b0;
      end else begin
         if (a_valid && !grant_a) begin
            if (starve != STARVE_LIM) begin
               starve <= starve + 1'b1;
            end
         end else begin
            starve <= '0;
         end

         a_rvalid <= a_rd_accept;
         if (a_rd_accept) begin
            a_rdata <= a_in_range ? m_rdata : 32'h0;
            a_err   <= !a_in_range;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural word memory behind the m_* port.
module tb_dm_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic [3:0]  c_be;
   logic        c_stall;
   logic        a_valid, a_ready, a_we;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_be;
   logic        a_rvalid, a_err;
   logic [29:0] m_addr;
   logic [31:0] m_wdata, m_rdata;
   logic        m_we;

   logic [31:0] mem [0:4095];
   int total = 0;
   int bad   = 0;

   dm_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_be(c_be), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_stall(c_stall),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_be(a_be),
      .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m_rdata = mem[m_addr[11:0]];
   always @(posedge clk) if (m_we) mem[m_addr[11:0]] <= m_wdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c_req = 0; c_we = 0; c_addr = 0; c_be = 0; c_wdata = 0;
      a_valid = 0; a_we = 0; a_addr = 0; a_be = 0; a_wdata = 0;
   endtask

   task automatic aux_write(input logic [31:0] addr, input logic [31:0] data);
      idle();
      a_valid = 1; a_we = 1; a_addr = addr; a_be = 4'hF; a_wdata = data;
      tick();
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      #12;
      check_eq("rst_rvalid", 32'(a_rvalid), 32'd0);
      check_eq("rst_rdata", a_rdata, 32'h0);
      check_eq("rst_err", 32'(a_err), 32'd0);
      check_eq("rst_starve", 32'(dut.starve), 32'd0);
      tick();
      reset = 1;

      // A full-word write at 0x10, then C reads it back
      a_valid = 1; a_we = 1; a_addr = 32'h10; a_be = 4'hF; a_wdata = 32'hDEADBEEF;
      #1;
      check_eq("a_wr_ready", 32'(a_ready), 32'd1);
      check_eq("a_wr_mwe", 32'(m_we), 32'd1);
      check_eq("a_wr_mwdata", m_wdata, 32'hDEADBEEF);
      tick();
      idle();
      c_req = 1; c_addr = 32'h10;
      #1;
      check_eq("c_rd_data", c_rdata, 32'hDEADBEEF);
      check_eq("c_rd_stall", 32'(c_stall), 32'd0);
      check_eq("a_wr_no_rvalid", 32'(a_rvalid), 32'd0);
      tick();

      aux_write(32'h44, 32'h11223344);
      aux_write(32'h20, 32'h12345678);
      aux_write(32'h0, 32'hCAFEF00D);

      // C byte store into lane 2
      c_req = 1; c_we = 1; c_addr = 32'h46; c_be = 4'b0100; c_wdata = 32'h00AA0000;
      #1;
      check_eq("sb_mwe", 32'(m_we), 32'd1);
      check_eq("sb_merge", m_wdata, 32'h11AA3344);
      tick();
      idle();
      c_req = 1; c_addr = 32'h44;
      #1;
      check_eq("sb_readback", c_rdata, 32'h11AA3344);
      tick();

      c_req = 1; c_we = 1; c_addr = 32'h44; c_be = 4'h0; c_wdata = 32'hFFFFFFFF;
      #1;
      check_eq("be0_nowrite", 32'(m_we), 32'd0);
      tick();
      idle();

      // Starvation: C every cycle, A held until forced grant on the 5th cycle
      c_req = 1; c_addr = 32'h10;
      a_valid = 1; a_we = 0; a_addr = 32'h20;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check_eq($sformatf("starve_ready_%0d", k), 32'(a_ready), (k == 5) ? 32'd1 : 32'd0);
         check_eq($sformatf("starve_stall_%0d", k), 32'(c_stall), (k == 5) ? 32'd1 : 32'd0);
         tick();
      end
      idle();
      check_eq("starve_cleared", 32'(dut.starve), 32'd0);
      check_eq("starve_rvalid", 32'(a_rvalid), 32'd1);
      check_eq("starve_rdata", a_rdata, 32'h12345678);
      tick();

      // A read with C idle
      a_valid = 1; a_we = 0; a_addr = 32'h20;
      #1;
      check_eq("a_rd_ready", 32'(a_ready), 32'd1);
      tick();
      idle();
      check_eq("a_rd_rvalid", 32'(a_rvalid), 32'd1);
      check_eq("a_rd_rdata", a_rdata, 32'h12345678);
      check_eq("a_rd_err", 32'(a_err), 32'd0);
      tick();
      check_eq("a_rd_pulse", 32'(a_rvalid), 32'd0);
      check_eq("a_rd_hold", a_rdata, 32'h12345678);

      // Out-of-range accesses alias word 0 in the model, which holds non-zero data
      a_valid = 1; a_we = 0; a_addr = 32'h0001_0000;
      tick();
      idle();
      check_eq("oor_rvalid", 32'(a_rvalid), 32'd1);
      check_eq("oor_rdata", a_rdata, 32'h0);
      check_eq("oor_err", 32'(a_err), 32'd1);
      c_req = 1; c_we = 1; c_addr = 32'h0001_0000; c_be = 4'hF; c_wdata = 32'h5A5A5A5A;
      #1;
      check_eq("oor_c_wr", 32'(m_we), 32'd0);
      c_we = 0;
      #1;
      check_eq("oor_c_rd", c_rdata, 32'h0);
      tick();
      idle();

      // Asynchronous reset the cycle after an accepted read
      a_valid = 1; a_we = 0; a_addr = 32'h20;
      tick();
      idle();
      reset = 0;
      #1;
      check_eq("arst_rvalid", 32'(a_rvalid), 32'd0);
      check_eq("arst_rdata", a_rdata, 32'h0);
      c_req = 1; c_we = 1; c_addr = 32'h10; c_be = 4'hF; c_wdata = 32'h55;
      #1;
      check_eq("arst_wr_driven", 32'(m_we), 32'd1);
      tick();
      check_eq("arst_rvalid_held", 32'(a_rvalid), 32'd0);
      reset = 1;
      idle();

      c_req = 1; c_addr = 32'h10;
      a_valid = 1; a_addr = 32'h20;
      tick();
      tick();
      check_eq("pre_rst_starve", 32'(dut.starve), 32'd2);
      reset = 0;
      #1;
      check_eq("arst_starve", 32'(dut.starve), 32'd0);
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
